seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
- Parametrised serial bit-sequence detector: successor to the fixed-pattern Mealy detector `fsm`.
- Pattern, pattern length and overlap mode are runtime-programmable.
- Output style (Mealy or registered) is set at elaboration.
- Adds an input-valid qualifier and a saturating match counter.
- Sits between a serial bit source and control logic that counts or reacts to framing sequences.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (>=2).
- CNT_W, 8: match counter width.
- MEALY, 1: 1 = outp combinational from the current input; 0 = outp registered, one cycle later.
- RST_PATTERN, 8'b0000_0101: pattern loaded at reset (low MAX_LEN bits used).
- RST_LEN, 3: pattern length loaded at reset.
- RST_OVERLAP, 1: overlap mode loaded at reset.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: reset, asynchronous, active-low.
- cfg_we, in, 1: load configuration this cycle.
- cfg_pattern, in, MAX_LEN: pattern; bit [len-1] is received first, bit [0] last.
- cfg_len, in, $clog2(MAX_LEN+1): pattern length.
- cfg_overlap, in, 1: 1 = overlapping matches counted; 0 = non-overlapping.
- inp, in, 1: serial data bit.
- in_valid, in, 1: inp is a valid beat this cycle.
- cnt_clr, in, 1: synchronous clear of match_cnt.
- outp, out, 1: match pulse.
- match_cnt, out, CNT_W: saturating count of matches.
- state, out, $clog2(MAX_LEN+1): number of valid history bits (fill), capped at the configured length.

Behaviour:
- Reset (rst=0, async):
  - history=0, state(fill)=0, match_cnt=0, outp=0, registered match=0.
  - Pattern, length and overlap take the RST_* values.
- Config storage: pat, len, ovl registers.
  - cfg_len=0 disables detection: outp never asserts, history still shifts.
  - cfg_len>MAX_LEN is clamped to MAX_LEN.
- cfg_we=1 (takes priority over in_valid the same cycle):
  - Latch cfg_* on the edge, clear history and fill to 0.
  - The input beat that cycle is dropped; outp=0 that cycle in both modes.
- Beat (in_valid=1, cfg_we=0):
  - ext = {history, inp}.
  - hit = (len!=0) && (fill >= len-1) && (ext[len-1:0] == pat[len-1:0]).
  - On the edge: history <= ext (low MAX_LEN-1 bits kept); fill <= min(fill+1, len).
- hit with ovl=0: fill <= 0, so the next match needs len fresh beats.
- hit with ovl=1: fill stays saturated and history is kept, so overlapping matches are allowed.
- in_valid=0: no state change, hit=0.
- MEALY=1: outp = hit, combinational in the same cycle as the beat.
- MEALY=0: outp = flop of hit; asserts for exactly one cycle after the completing beat's edge.
- match_cnt:
  - Increments on the edge of every hit.
  - Saturates at 2^CNT_W-1.
  - cnt_clr=1 with a simultaneous hit: cnt_clr wins, result 0.
  - cfg_we does not clear match_cnt.
- Reset asserted mid-sequence: the partial match is discarded immediately; the registered outp drops asynchronously.
- state output reports fill, so a bench can trace the detector's progress per beat.

Decomposition:
- Shared package seq_detect_pkg holds:
  - the len-width function (clog2 of MAX_LEN+1);
  - default pattern constants (PAT_101, PAT_1011);
  - overlap mode encodings OVL_ON and OVL_OFF.
- One sub-module is natural: sat_counter (parameter CNT_W; inputs inc and clr; clr priority; saturating). It is reused elsewhere for statistics counters.
- Matching and shift logic stay in the top module.

Test Plan:
- Stream (reset config 101, overlap, MEALY=1):
  - Feed 16'b0101_0111_0111_0010 LSB first, in_valid=1 every beat.
  - Required: outp=1 at beats 8, 12, 14 only; match_cnt=3.
- Non-overlap:
  - Same stream after cfg_we with pattern=101, len=3, overlap=0.
  - Required: outp at beats 8, 12 only; match_cnt=2 (3+2=5 if not cleared).
- Registered mode (MEALY=0), pattern 1011, len 4:
  - Same stream.
  - Required: outp high only in the cycle after beat 9; fill=4 at that point.
- Gaps and config priority:
  - Insert in_valid=0 cycles between the bits of 101; required: detection unchanged.
  - Assert cfg_we together with the completing beat; required: no outp, fill=0.
- Saturation and clear:
  - CNT_W=2, pattern 1, len 1, five 1-beats; required: match_cnt stays at 3.
  - cnt_clr on a hit cycle; required: match_cnt=0.
- Async reset:
  - rst low mid-pattern (fill=2) between clock edges.
  - Required: state=0, outp=0 immediately, match_cnt=0, pattern=101.
  - Re-run a short stream and confirm reset config behaviour.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared definitions for the programmable serial sequence detector:
// length-field sizing, default patterns and overlap-mode encodings.
package seq_detect_pkg;

    // Width of a length field able to hold 0..max_len inclusive.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Commonly used framing patterns (bit [len-1] arrives first).
    localparam logic [7:0] PAT_101  = 8'b0000_0101;
    localparam logic [7:0] PAT_1011 = 8'b0000_1011;

    // Overlap mode encodings for cfg_overlap.
    localparam logic OVL_OFF = 1'b0;
    localparam logic OVL_ON  = 1'b1;

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count up on inc, hold at all-ones, clear takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial bit-sequence detector with valid qualifier,
// overlap control, Mealy or registered match pulse and saturating match count.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter bit                 MEALY       = 1'b1,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(PAT_101),
    parameter int                 RST_LEN     = 3,
    parameter bit                 RST_OVERLAP = OVL_ON
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [MAX_LEN-1:0]         cfg_pattern,
    input  logic [len_w(MAX_LEN)-1:0]  cfg_len,
    input  logic                       cfg_overlap,
    input  logic                       inp,
    input  logic                       in_valid,
    input  logic                       cnt_clr,
    output logic                       outp,
    output logic [CNT_W-1:0]           match_cnt,
    output logic [len_w(MAX_LEN)-1:0]  state
);

    localparam int             LW        = len_w(MAX_LEN);
    localparam logic [LW-1:0]  MAX_LEN_C = LW'(MAX_LEN);
    localparam logic [LW-1:0]  RST_LEN_C = (RST_LEN > MAX_LEN) ? MAX_LEN_C : LW'(RST_LEN);

    logic [MAX_LEN-1:0] r_pat;
    logic [LW-1:0]      r_len;
    logic               r_ovl;
    logic [MAX_LEN-2:0] r_hist;
    logic [LW-1:0]      r_fill;

    logic [MAX_LEN-1:0] w_ext;
    logic [MAX_LEN-1:0] w_mask;
    logic [LW-1:0]      w_cfg_len;
    logic               w_beat;
    logic               w_fill_ok;
    logic               w_hit;

    // Newest bit lands in bit 0, so the pattern's last bit lines up with ext[0].
    assign w_ext     = {r_hist, inp};
    assign w_cfg_len = (cfg_len > MAX_LEN_C) ? MAX_LEN_C : cfg_len;
    assign w_beat    = in_valid && !cfg_we;
    // fill >= len-1 written as fill+1 >= len to avoid underflow at len=0.
    assign w_fill_ok = (({1'b0, r_fill} + (LW+1)'(1)) >= {1'b0, r_len});

    // Select the low len bits of history and pattern for comparison.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_hit = w_beat && (r_len != '0) && w_fill_ok &&
                   ((w_ext & w_mask) == (r_pat & w_mask));

    // Configuration latch, history shift and fill tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pat  <= RST_PATTERN;
            r_len  <= RST_LEN_C;
            r_ovl  <= RST_OVERLAP;
            r_hist <= '0;
            r_fill <= '0;
        end else if (cfg_we) begin
            r_pat  <= cfg_pattern;
            r_len  <= w_cfg_len;
            r_ovl  <= cfg_overlap;
            r_hist <= '0;
            r_fill <= '0;
        end else if (in_valid) begin
            r_hist <= w_ext[MAX_LEN-2:0];
            if (w_hit && (r_ovl == OVL_OFF)) begin
                r_fill <= '0;
            end else if (r_fill < r_len) begin
                r_fill <= r_fill + LW'(1);
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_hit),
        .clr (cnt_clr),
        .cnt (match_cnt)
    );

    generate
        if (MEALY) begin : g_mealy
            assign outp = w_hit;
        end else begin : g_reg
            logic r_hit;
            // Registered match pulse, one cycle after the completing beat.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_hit <= 1'b0;
                end else begin
                    r_hit <= w_hit;
                end
            end
            assign outp = r_hit;
        end
    endgenerate

    assign state = r_fill;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: Mealy, registered and 2-bit-counter
// instances share one stimulus stream.
module tb_seq_detect_param;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       inp;
    logic       in_valid;
    logic       cnt_clr;

    logic       outp_m, outp_r, outp_s;
    logic [7:0] cnt_m, cnt_r;
    logic [1:0] cnt_s;
    logic [3:0] st_m, st_r, st_s;

    int n_chk = 0;
    int n_fail = 0;

    logic [15:0] stream_v = 16'b0101_0111_0111_0010;

    seq_detect_param #(.MEALY(1'b1)) dut_m (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .inp(inp),
        .in_valid(in_valid), .cnt_clr(cnt_clr), .outp(outp_m),
        .match_cnt(cnt_m), .state(st_m)
    );

    seq_detect_param #(.MEALY(1'b0)) dut_r (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .inp(inp),
        .in_valid(in_valid), .cnt_clr(cnt_clr), .outp(outp_r),
        .match_cnt(cnt_r), .state(st_r)
    );

    seq_detect_param #(.MEALY(1'b1), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .inp(inp),
        .in_valid(in_valid), .cnt_clr(cnt_clr), .outp(outp_s),
        .match_cnt(cnt_s), .state(st_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus driven at the falling edge; outputs settle 1ns later.
    task automatic step(input logic b, input logic v, input logic cc);
        @(negedge clk);
        cfg_we   = 1'b0;
        inp      = b;
        in_valid = v;
        cnt_clr  = cc;
        #1;
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic b);
        @(negedge clk);
        cfg_we      = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        inp         = b;
        in_valid    = 1'b1;
        cnt_clr     = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_chk++;
        if (outp_m !== 1'b0 || outp_r !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outp got m=%b r=%b expected 0", outp_m, outp_r);
        end
        n_chk++;
        if (cnt_m !== 8'd0 || st_m !== 4'd0 || st_r !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state got cnt=%0d st_m=%0d st_r=%0d expected 0", cnt_m, st_m, st_r);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_overlap_stream();
        logic em, er;
        for (int i = 0; i < 16; i++) begin
            step(stream_v[i], 1'b1, 1'b0);
            em = (i == 8) || (i == 12) || (i == 14);
            er = (i == 9) || (i == 13) || (i == 15);
            n_chk++;
            if (outp_m !== em) begin
                n_fail++;
                $display("FAIL ovl_mealy beat %0d got %b expected %b", i, outp_m, em);
            end
            n_chk++;
            if (outp_r !== er) begin
                n_fail++;
                $display("FAIL ovl_reg beat %0d got %b expected %b", i, outp_r, er);
            end
        end
        step(1'b0, 1'b0, 1'b0);
        n_chk++;
        if (cnt_m !== 8'd3 || cnt_r !== 8'd3) begin
            n_fail++;
            $display("FAIL ovl_count got m=%0d r=%0d expected 3", cnt_m, cnt_r);
        end
    endtask

    task automatic test_non_overlap();
        logic em, er;
        cfg(8'b0000_0101, 4'd3, 1'b0, 1'b1);
        n_chk++;
        if (outp_m !== 1'b0) begin
            n_fail++;
            $display("FAIL nonovl_cfg_outp got %b expected 0", outp_m);
        end
        for (int i = 0; i < 16; i++) begin
            step(stream_v[i], 1'b1, 1'b0);
            if (i == 0) begin
                n_chk++;
                if (st_m !== 4'd0) begin
                    n_fail++;
                    $display("FAIL nonovl_fill_after_cfg got %0d expected 0", st_m);
                end
            end
            em = (i == 8) || (i == 12);
            er = (i == 9) || (i == 13);
            n_chk++;
            if (outp_m !== em) begin
                n_fail++;
                $display("FAIL nonovl_mealy beat %0d got %b expected %b", i, outp_m, em);
            end
            n_chk++;
            if (outp_r !== er) begin
                n_fail++;
                $display("FAIL nonovl_reg beat %0d got %b expected %b", i, outp_r, er);
            end
        end
        step(1'b0, 1'b0, 1'b0);
        n_chk++;
        if (cnt_m !== 8'd5) begin
            n_fail++;
            $display("FAIL nonovl_count got %0d expected 5", cnt_m);
        end
    endtask

    task automatic test_registered();
        logic em, er;
        cfg(8'b0000_1011, 4'd4, 1'b1, 1'b0);
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) step(stream_v[i], 1'b1, 1'b0);
            else        step(1'b0, 1'b0, 1'b0);
            em = (i == 9);
            er = (i == 10);
            n_chk++;
            if (outp_r !== er) begin
                n_fail++;
                $display("FAIL reg_outp beat %0d got %b expected %b", i, outp_r, er);
            end
            n_chk++;
            if (outp_m !== em) begin
                n_fail++;
                $display("FAIL reg_mealy_ref beat %0d got %b expected %b", i, outp_m, em);
            end
            if (i == 10) begin
                n_chk++;
                if (st_r !== 4'd4) begin
                    n_fail++;
                    $display("FAIL reg_fill got %0d expected 4", st_r);
                end
            end
        end
        n_chk++;
        if (cnt_m !== 8'd6) begin
            n_fail++;
            $display("FAIL reg_count got %0d expected 6", cnt_m);
        end
    endtask

    task automatic test_gaps_and_priority();
        logic gi [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic gv [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic em;
        cfg(8'b0000_0101, 4'd3, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(gi[i], gv[i], 1'b0);
            em = (i == 5);
            n_chk++;
            if (outp_m !== em) begin
                n_fail++;
                $display("FAIL gaps step %0d got %b expected %b", i, outp_m, em);
            end
        end
        step(1'b0, 1'b0, 1'b0);
        n_chk++;
        if (st_m !== 4'd3 || cnt_m !== 8'd7) begin
            n_fail++;
            $display("FAIL gaps_state got fill=%0d cnt=%0d expected 3/7", st_m, cnt_m);
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        cfg(8'b0000_0101, 4'd3, 1'b1, 1'b1);
        n_chk++;
        if (outp_m !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_priority_outp got %b expected 0", outp_m);
        end
        step(1'b0, 1'b0, 1'b0);
        n_chk++;
        if (st_m !== 4'd0 || outp_r !== 1'b0 || cnt_m !== 8'd7) begin
            n_fail++;
            $display("FAIL cfg_priority_state got fill=%0d reg=%b cnt=%0d expected 0/0/7",
                     st_m, outp_r, cnt_m);
        end
    endtask

    task automatic test_len_bounds();
        cfg(8'hA5, 4'd15, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        n_chk++;
        if (st_m !== 4'd8) begin
            n_fail++;
            $display("FAIL len_clamp_fill got %0d expected 8", st_m);
        end
        cfg(8'h00, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            n_chk++;
            if (outp_m !== 1'b0) begin
                n_fail++;
                $display("FAIL len0_outp beat %0d got %b expected 0", i, outp_m);
            end
        end
        step(1'b0, 1'b0, 1'b0);
        n_chk++;
        if (st_m !== 4'd0 || cnt_m !== 8'd7) begin
            n_fail++;
            $display("FAIL len0_state got fill=%0d cnt=%0d expected 0/7", st_m, cnt_m);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] es;
        cfg(8'h01, 4'd1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 1'b0);
            es = (k < 3) ? 2'(k) : 2'd3;
            n_chk++;
            if (cnt_s !== es || outp_s !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_count beat %0d got cnt=%0d outp=%b expected %0d/1",
                         k, cnt_s, outp_s, es);
            end
        end
        step(1'b0, 1'b0, 1'b0);
        n_chk++;
        if (cnt_s !== 2'd3 || cnt_m !== 8'd5) begin
            n_fail++;
            $display("FAIL sat_final got s=%0d m=%0d expected 3/5", cnt_s, cnt_m);
        end
        step(1'b1, 1'b1, 1'b1);
        n_chk++;
        if (outp_m !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_hit_outp got %b expected 1", outp_m);
        end
        step(1'b0, 1'b0, 1'b0);
        n_chk++;
        if (cnt_s !== 2'd0 || cnt_m !== 8'd0) begin
            n_fail++;
            $display("FAIL clr_priority got s=%0d m=%0d expected 0", cnt_s, cnt_m);
        end
    endtask

    task automatic test_async_reset();
        logic em;
        cfg(8'h03, 4'd2, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        n_chk++;
        if (st_r !== 4'd2 || outp_r !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset got fill=%0d reg=%b expected 2/1", st_r, outp_r);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_chk++;
        if (st_m !== 4'd0 || st_r !== 4'd0 || outp_r !== 1'b0 || outp_m !== 1'b0 || cnt_m !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset got fill=%0d/%0d reg=%b mealy=%b cnt=%0d expected all 0",
                     st_m, st_r, outp_r, outp_m, cnt_m);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step((i != 1), 1'b1, 1'b0);
            em = (i == 2);
            n_chk++;
            if (outp_m !== em) begin
                n_fail++;
                $display("FAIL post_reset_101 beat %0d got %b expected %b", i, outp_m, em);
            end
        end
        step(1'b0, 1'b0, 1'b0);
        n_chk++;
        if (cnt_m !== 8'd1) begin
            n_fail++;
            $display("FAIL post_reset_count got %0d expected 1", cnt_m);
        end
    endtask

    initial begin
        rst         = 1'b0;
        cfg_we      = 1'b0;
        cfg_pattern = 8'h00;
        cfg_len     = 4'd0;
        cfg_overlap = 1'b0;
        inp         = 1'b0;
        in_valid    = 1'b0;
        cnt_clr     = 1'b0;
        test_reset();
        test_overlap_stream();
        test_non_overlap();
        test_registered();
        test_gaps_and_priority();
        test_len_bounds();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
